alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001: The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset_n  input  1  asynchronous active-low reset.
REQ-004: flush  input  1  synchronous abort of any in-flight operation.
REQ-005: in_valid  input  1  operation presented.
REQ-006: in_ready  output  1  stage can accept; high only in IDLE.
REQ-007: alu_ctrl  input  4  operation code from the ALU control decoder (encoding in REQ-013).
REQ-008: a  input  32  operand A (rs).
REQ-009: b  input  32  operand B (rt or immediate).
REQ-010: shamt  input  5  shift amount for fixed shifts.
REQ-011: out_valid  output  1  result available; out_ready  input  1  consumer accepts.
REQ-012: result  output  32  registered result; zero  output  1  result==0; overflow  output  1  signed add/sub overflow.

Function
REQ-013: Codes SHALL be:
- 0000: nop, result 0.
- 0001 sll, 0010 srl, 0011 sra: shift b by shamt.
- 0100 sllv, 0101 srlv, 0110 srav: shift b by a[4:0].
- 0111 lui: {b[15:0],16'h0}.
- 1000 add, 1001 sub (a-b).
- 1010 and, 1011 or, 1100 xor, 1101 nor.
- 1110 slt (signed), 1111 sltu (unsigned): result 1 or 0, zero-extended.
REQ-014: FSM states SHALL be IDLE, SHIFT, DONE.
REQ-015: Accept occurs on a rising edge with in_valid=1 and in_ready=1; operands and code are captured on that edge and later input changes are ignored.
REQ-016: Shift code with effective amount N>0: accepting edge -> SHIFT, accumulator=b, counter=N.
REQ-017: Any other code, or shift with N=0 (result=b): accepting edge -> DONE with the result computed combinationally from captured inputs.
REQ-018: SHIFT SHALL shift the accumulator one bit per edge (sra/srav replicate bit 31; srl/srlv fill 0; sll/sllv fill 0) and decrement the counter; the edge where the counter goes 1->0 SHALL move to DONE with result = accumulator.
REQ-019: Latency: out_valid first high N edges after the accepting edge (N=0 for non-shift ops, i.e. the cycle immediately after accept).
REQ-020: DONE: out_valid=1; result, zero and overflow held stable until the edge where out_valid=1 and out_ready=1, which returns the FSM to IDLE.
REQ-021: in_ready SHALL be 0 in SHIFT and DONE; no new operation is accepted in the cycle a result is consumed (peak throughput 1 op per 2 cycles).
REQ-022: overflow SHALL be 1 only for add/sub when the operand signs and result sign indicate 32-bit two's-complement overflow, otherwise 0; the result SHALL always wrap mod 2^32.
REQ-023: zero SHALL equal (result==0) for every code, including nop (zero=1).
REQ-024: flush=1 at an edge SHALL force IDLE, out_valid=0 and discard the operation, with priority over accept, shift and consume.
REQ-025: If out_ready is held high, the result SHALL still be visible for at least one cycle with out_valid=1.

Reset
REQ-026: reset_n=0 SHALL immediately, without a clock edge, set state=IDLE, out_valid=0, result=0, zero=0, overflow=0, counter=0 and accumulator=0, and discard any in-flight operation.
REQ-027: While reset_n=0, in_valid and out_ready SHALL be ignored; the first accept is possible on the first rising edge after reset_n rises.

Verification
REQ-028: add a=0x7FFFFFFF, b=0x00000001 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0.
REQ-029: sra b=0x80000000, shamt=4 -> in_ready=0 for 4 cycles; then result=0xF8000000, out_valid=1.
REQ-030: srlv a=0x00000023, b=0x000000F0 -> out_valid after 3 edges, result=0x0000001E; sll with shamt=0, b=0x1234 -> result=0x1234 after 1 cycle.
REQ-031: slt a=1, b=0xFFFFFFFF -> result=0; sltu with the same operands -> result=1; sub a=b=5 -> result=0, zero=1, overflow=0.
REQ-032: out_ready held 0 for 5 cycles after DONE -> result stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge and a new op is accepted the following cycle.
REQ-033: reset_n pulsed low mid-SHIFT (sll shamt=20, after 7 edges) -> out_valid=0 and result=0 immediately, no stale result afterwards; a repeat with flush=1 instead gives the same outcome at the next edge.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Multi-cycle ALU execute stage: single-cycle ALU ops plus bit-serial shifts,
// with a valid/ready handshake on both sides.
module alu_exec_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [4:0]        shamt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] KIND_SLL = 2'd0;
    localparam logic [1:0] KIND_SRL = 2'd1;
    localparam logic [1:0] KIND_SRA = 2'd2;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] acc;
    logic [4:0]        cnt;
    logic [1:0]        kind;

    logic              is_shift;
    logic [4:0]        amt;
    logic [1:0]        kind_in;
    logic [DATA_W-1:0] eval_res;
    logic              eval_ovf;
    logic [DATA_W-1:0] step_res;

    // Non-shift ALU evaluation; returns {overflow, result}.
    function automatic logic [DATA_W:0] alu_eval(input logic [3:0]        ctrl,
                                                 input logic [DATA_W-1:0] op_a,
                                                 input logic [DATA_W-1:0] op_b);
        logic signed [DATA_W-1:0] sa;
        logic signed [DATA_W-1:0] sb;
        logic signed [DATA_W-1:0] sr;
        logic                     ovf;
        sa  = $signed(op_a);
        sb  = $signed(op_b);
        sr  = '0;
        ovf = 1'b0;
        case (ctrl)
            4'h7: sr = $signed({op_b[15:0], 16'h0000});
            4'h8: begin
                sr  = sa + sb;
                ovf = (sa[DATA_W-1] == sb[DATA_W-1]) && (sr[DATA_W-1] != sa[DATA_W-1]);
            end
            4'h9: begin
                sr  = sa - sb;
                ovf = (sa[DATA_W-1] != sb[DATA_W-1]) && (sr[DATA_W-1] != sa[DATA_W-1]);
            end
            4'hA: sr = sa & sb;
            4'hB: sr = sa | sb;
            4'hC: sr = sa ^ sb;
            4'hD: sr = ~(sa | sb);
            4'hE: sr = $signed({{(DATA_W-1){1'b0}}, (sa < sb)});
            4'hF: sr = $signed({{(DATA_W-1){1'b0}}, (op_a < op_b)});
            default: sr = '0;
        endcase
        return {ovf, sr};
    endfunction

    function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v,
                                                    input logic [1:0]        k);
        logic [DATA_W-1:0] r;
        case (k)
            KIND_SRL: r = {1'b0, v[DATA_W-1:1]};
            KIND_SRA: r = {v[DATA_W-1], v[DATA_W-1:1]};
            default:  r = {v[DATA_W-2:0], 1'b0};
        endcase
        return r;
    endfunction

    always_comb begin
        is_shift = (alu_ctrl != 4'h0) && (alu_ctrl <= 4'h6);
        amt      = alu_ctrl[2] ? a[4:0] : shamt;
        case (alu_ctrl)
            4'h2, 4'h5: kind_in = KIND_SRL;
            4'h3, 4'h6: kind_in = KIND_SRA;
            default:    kind_in = KIND_SLL;
        endcase
        // A shift by zero completes immediately with b passed through.
        if (is_shift) begin
            eval_res = b;
            eval_ovf = 1'b0;
        end else begin
            {eval_ovf, eval_res} = alu_eval(alu_ctrl, a, b);
        end
        step_res = shift_one(acc, kind);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (is_shift && (amt != 5'd0)) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (cnt <= 5'd1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            cnt      <= '0;
            kind     <= KIND_SLL;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_shift && (amt != 5'd0)) begin
                            acc  <= b;
                            cnt  <= amt;
                            kind <= kind_in;
                        end else begin
                            result   <= eval_res;
                            zero     <= (eval_res == '0);
                            overflow <= eval_ovf;
                        end
                    end
                end
                SHIFT: begin
                    acc <= step_res;
                    cnt <= cnt - 5'd1;
                    if (cnt <= 5'd1) begin
                        result   <= step_res;
                        zero     <= (step_res == '0);
                        overflow <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed and random bench for alu_exec_stage with a queue of expected results.
module tb_alu_exec_stage;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_exec_stage #(.DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] av,
                                   input logic [31:0] bv, input logic [4:0] sh);
        exp_t        e;
        logic [4:0]  n;
        logic [31:0] r;
        logic        v;
        n = (c >= 4'h4 && c <= 4'h6) ? av[4:0] : sh;
        r = 32'h0;
        v = 1'b0;
        case (c)
            4'h1, 4'h4: r = bv << n;
            4'h2, 4'h5: r = bv >> n;
            4'h3, 4'h6: r = $signed(bv) >>> n;
            4'h7: r = {bv[15:0], 16'h0};
            4'h8: begin r = av + bv; v = (av[31] == bv[31]) && (r[31] != av[31]); end
            4'h9: begin r = av - bv; v = (av[31] != bv[31]) && (r[31] != av[31]); end
            4'hA: r = av & bv;
            4'hB: r = av | bv;
            4'hC: r = av ^ bv;
            4'hD: r = ~(av | bv);
            4'hE: r = ($signed(av) < $signed(bv)) ? 32'd1 : 32'd0;
            4'hF: r = (av < bv) ? 32'd1 : 32'd0;
            default: r = 32'h0;
        endcase
        e.res = r;
        e.z   = (r == 32'h0);
        e.ovf = v;
        e.lat = (c >= 4'h1 && c <= 4'h6) ? int'(n) : 0;
        return e;
    endfunction

    task automatic run_op(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                          input logic [4:0] sh, input int hold, input bit pre_ready);
        exp_t e;
        int   lat;
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        alu_ctrl  = c;
        a         = av;
        b         = bv;
        shamt     = sh;
        in_valid  = 1'b1;
        out_ready = pre_ready;
        sb.push_back(model(c, av, bv, sh));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctrl = ~c;
        a        = ~av;
        b        = ~bv;
        shamt    = ~sh;
        lat = 0;
        while (!out_valid && lat < 64) begin
            check("in_ready_busy", {31'b0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid", {31'b0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("latency", lat, e.lat);
            check("result", result, e.res);
            check("zero", {31'b0, zero}, {31'b0, e.z});
            check("overflow", {31'b0, overflow}, {31'b0, e.ovf});
            check("in_ready_done", {31'b0, in_ready}, 32'd0);
            if (!pre_ready) begin
                for (int i = 0; i < hold; i++) begin
                    @(posedge clk);
                    #1;
                    check("hold_valid", {31'b0, out_valid}, 32'd1);
                    check("hold_result", result, e.res);
                    check("hold_in_ready", {31'b0, in_ready}, 32'd0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("consumed_valid", {31'b0, out_valid}, 32'd0);
            check("consumed_in_ready", {31'b0, in_ready}, 32'd1);
        end
    endtask

    task automatic watch_no_valid(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check(tag, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        alu_ctrl  = 4'h8;
        a         = 32'h1;
        b         = 32'h2;
        shamt     = 5'd0;
        #3;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        #17;
        check("rst_ignore_valid", {31'b0, out_valid}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        reset_n   = 1'b1;

        run_op(4'h8, 32'h7FFFFFFF, 32'h00000001, 5'd0, 0, 1'b0);
        run_op(4'h3, 32'h0, 32'h80000000, 5'd4, 0, 1'b0);
        run_op(4'h5, 32'h00000023, 32'h000000F0, 5'd0, 0, 1'b0);
        run_op(4'h1, 32'h0, 32'h00001234, 5'd0, 0, 1'b0);
        run_op(4'hE, 32'h1, 32'hFFFFFFFF, 5'd0, 0, 1'b0);
        run_op(4'hF, 32'h1, 32'hFFFFFFFF, 5'd0, 0, 1'b0);
        run_op(4'h9, 32'h5, 32'h5, 5'd0, 0, 1'b0);
        run_op(4'h0, 32'hDEAD, 32'hBEEF, 5'd3, 0, 1'b0);
        run_op(4'hC, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 5, 1'b0);
        run_op(4'hA, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 0, 1'b1);
        run_op(4'h6, 32'hFFFFFFFF, 32'h80000001, 5'd0, 0, 1'b1);
        run_op(4'h9, 32'h80000000, 32'h00000001, 5'd0, 1, 1'b0);
        run_op(4'h7, 32'h0, 32'hABCD5678, 5'd0, 0, 1'b0);
        run_op(4'hD, 32'h0000FFFF, 32'h00FF0000, 5'd0, 0, 1'b0);
        run_op(4'hB, 32'h12340000, 32'h00005678, 5'd0, 0, 1'b0);
        run_op(4'h2, 32'h0, 32'h80000000, 5'd31, 0, 1'b0);
        run_op(4'h4, 32'hFFFFFFE1, 32'h00000003, 5'd7, 0, 1'b0);

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        alu_ctrl = 4'h1;
        b        = 32'h1;
        shamt    = 5'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_result", result, 32'h0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_held_valid", {31'b0, out_valid}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        watch_no_valid("midrst_stale");
        check("midrst_result_after", result, 32'h0);

        run_op(4'hB, 32'h00000010, 32'h00000001, 5'd0, 0, 1'b0);

        // Same abort via synchronous flush.
        @(negedge clk);
        alu_ctrl = 4'h1;
        b        = 32'h1;
        shamt    = 5'd20;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_result", result, 32'h0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        watch_no_valid("flush_stale");

        // Flush wins over a simultaneous accept.
        @(negedge clk);
        alu_ctrl = 4'h8;
        a        = 32'h1;
        b        = 32'h1;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_accept_valid", {31'b0, out_valid}, 32'd0);
        check("flush_accept_ready", {31'b0, in_ready}, 32'd1);

        for (int k = 0; k < 30; k++) begin
            run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
